// File: rtl/sys_cmd_initiator.sv
// sys_cmd_initiator: frames register-file/ALU commands into a UART byte stream
// and collects the one- or two-byte response, with a response timeout.
module sys_cmd_initiator #(
   parameter int DATA_WD        = 8,
   parameter int ADDR_WD        = 4,
   parameter int FUN_WD         = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CMD_VALID,
   output logic                 CMD_READY,
   input  logic [1:0]           CMD_TYPE,
   input  logic [ADDR_WD-1:0]   CMD_ADDR,
   input  logic [DATA_WD-1:0]   CMD_OP_A,
   input  logic [DATA_WD-1:0]   CMD_OP_B,
   input  logic [FUN_WD-1:0]    CMD_FUN,
   output logic [DATA_WD-1:0]   TX_DATA,
   output logic                 TX_VALID,
   input  logic                 TX_READY,
   input  logic [DATA_WD-1:0]   RX_DATA,
   input  logic                 RX_VALID,
   output logic [2*DATA_WD-1:0] RSP_DATA,
   output logic                 CMD_DONE,
   output logic                 TIMEOUT,
   output logic                 BUSY
);
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, FINISH} state_t;
   state_t state, nxt;

   logic [1:0]         typ, idx, last_idx;
   logic [ADDR_WD-1:0] addr;
   logic [DATA_WD-1:0] op_a, op_b, hdr, b1, b2, cur;
   logic [FUN_WD-1:0]  fun;
   logic [TW-1:0]      tmr;
   logic               rx_cnt, tx_fire, rx_last, expire;

   // frame byte at the current index, and the index of the last byte
   always_comb begin
      hdr = typ == 2'd0 ? DATA_WD'(8'hAA) : typ == 2'd1 ? DATA_WD'(8'hBB) :
            typ == 2'd2 ? DATA_WD'(8'hCC) : DATA_WD'(8'hDD);
      b1 = typ == 2'd2 ? op_a : typ == 2'd3 ? DATA_WD'(fun) : DATA_WD'(addr);
      b2 = typ == 2'd0 ? op_a : op_b;
      cur = idx == 2'd0 ? hdr : idx == 2'd1 ? b1 : idx == 2'd2 ? b2 : DATA_WD'(fun);
      last_idx = typ == 2'd2 ? 2'd3 : typ == 2'd0 ? 2'd2 : 2'd1;
   end

   assign CMD_READY = state == IDLE;
   assign BUSY      = ~CMD_READY;
   assign TX_VALID  = state == SEND;
   assign TX_DATA   = TX_VALID ? cur : '0;
   assign CMD_DONE  = state == FINISH;
   assign tx_fire   = TX_VALID & TX_READY;
   assign rx_last   = typ == 2'd1 || rx_cnt;
   // a byte arriving on the expiry cycle wins over the timeout
   assign expire    = state == WAIT_RSP && !RX_VALID && tmr == T_LAST;
   assign TIMEOUT   = expire;

   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= IDLE;
      else     state <= nxt;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:     nxt = CMD_VALID ? SEND : IDLE;
         SEND:     nxt = tx_fire && idx == last_idx ? (typ == 2'd0 ? FINISH : WAIT_RSP) : SEND;
         WAIT_RSP: nxt = RX_VALID && rx_last ? FINISH : expire ? IDLE : WAIT_RSP;
         default:  nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         typ      <= '0;
         idx      <= '0;
         addr     <= '0;
         op_a     <= '0;
         op_b     <= '0;
         fun      <= '0;
         rx_cnt   <= 1'b0;
         tmr      <= '0;
         RSP_DATA <= '0;
      end else if (state == IDLE) begin
         if (CMD_VALID) begin
            typ      <= CMD_TYPE;
            addr     <= CMD_ADDR;
            op_a     <= CMD_OP_A;
            op_b     <= CMD_OP_B;
            fun      <= CMD_FUN;
            idx      <= '0;
            rx_cnt   <= 1'b0;
            tmr      <= '0;
            RSP_DATA <= '0;
         end
      end else if (state == SEND) begin
         if (tx_fire) idx <= idx + 2'd1;
      end else if (state == WAIT_RSP) begin
         if (RX_VALID) begin
            tmr    <= '0;
            rx_cnt <= 1'b1;
            if (rx_cnt) RSP_DATA[2*DATA_WD-1:DATA_WD] <= RX_DATA;
            else        RSP_DATA[DATA_WD-1:0] <= RX_DATA;
         end else if (expire) begin
            RSP_DATA <= '0;
         end else begin
            tmr <= tmr + 1'b1;
         end
      end
endmodule
